// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed dual-bus 7-segment driver.
// Two digit banks are scanned in parallel. Positions i and i+DIGITS/2 are lit
// together on seg_out0 and seg_out1. Each digit has a decimal point, a blank
// and a blink mask. The whole digit field can scroll left circularly.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   digits    hex code per digit; digit 0 is the leftmost (most significant) nibble
//   dp        decimal point per digit (bit p = digit p)
//   blank     force digit dark (bit p = digit p)
//   blink     digit dark during the blink off-phase (bit p = digit p)
//   scroll_en enable circular left scroll
//   seg_en    digit enables, active-high
//   seg_out0  segments {a,b,c,d,e,f,g,dp} for digits 0..DIGITS/2-1
//   seg_out1  segments {a,b,c,d,e,f,g,dp} for digits DIGITS/2..DIGITS-1
module seg_scan_display #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLINK_DIV  = 50000000,
  parameter int unsigned SCROLL_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  scroll_en,
  output logic [DIGITS-1:0]     seg_en,
  output logic [7:0]            seg_out0,
  output logic [7:0]            seg_out1
);

  localparam int unsigned H        = DIGITS / 2;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned IDX_W    = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned OFF_W    = $clog2(DIGITS);

  if (DIGITS < 2 || (DIGITS % 2) != 0) begin : g_bad_digits
    $error("seg_scan_display: DIGITS must be even and at least 2");
  end

  function automatic logic [7:0] glyph(input logic [3:0] c);
    logic [7:0] g;
    case (c)
      4'h0: g = 8'hFC;
      4'h1: g = 8'h60;
      4'h2: g = 8'hDA;
      4'h3: g = 8'hF2;
      4'h4: g = 8'h66;
      4'h5: g = 8'hB6;
      4'h6: g = 8'hBE;
      4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;
      4'h9: g = 8'hF6;
      4'hA: g = 8'hEE;
      4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;
      4'hD: g = 8'h7A;
      4'hE: g = 8'h9E;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // (p + off) mod DIGITS; both operands are below DIGITS, so one subtract suffices
  // and it stays exact for non-power-of-2 digit counts.
  function automatic logic [OFF_W-1:0] rot(input logic [OFF_W-1:0] p,
                                           input logic [OFF_W-1:0] off);
    int unsigned sum;
    sum = 32'(p) + 32'(off);
    if (sum >= DIGITS) sum = sum - DIGITS;
    return OFF_W'(sum);
  endfunction

  logic [3:0] code [DIGITS];
  for (genvar p = 0; p < DIGITS; p++) begin : g_code
    assign code[p] = digits[4*(DIGITS-1-p) +: 4];
  end

  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [DIGITS-1:0]   seg_en_q, seg_en_d;
  logic [7:0]          out0_q, out0_d, out1_q, out1_d;

  logic [OFF_W-1:0]    pos_lo, pos_hi, src_lo, src_hi;
  logic                dark_lo, dark_hi;

  // Counters, index, blink phase and scroll offset.
  always_comb begin
    scan_cnt_d   = scan_cnt_q + SCAN_W'(1);
    idx_d        = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(H - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    blink_cnt_d  = blink_cnt_q + BLINK_W'(1);
    phase_d      = phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    scroll_cnt_d = '0;
    offset_d     = '0;
    if (scroll_en) begin
      scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
      offset_d     = offset_q;
      if (scroll_cnt_q == SCROLL_W'(SCROLL_DIV - 1)) begin
        scroll_cnt_d = '0;
        offset_d     = (offset_q == OFF_W'(DIGITS - 1)) ? '0 : offset_q + OFF_W'(1);
      end
    end
  end

  // Output pair from the current index, offset and phase; registered below.
  always_comb begin
    pos_lo   = OFF_W'(idx_q);
    pos_hi   = OFF_W'(32'(idx_q) + H);
    src_lo   = rot(pos_lo, offset_q);
    src_hi   = rot(pos_hi, offset_q);
    dark_lo  = blank[src_lo] | (blink[src_lo] & phase_q);
    dark_hi  = blank[src_hi] | (blink[src_hi] & phase_q);
    seg_en_d = '0;
    out0_d   = 8'h00;
    out1_d   = 8'h00;
    if (!dark_lo) begin
      seg_en_d[pos_lo] = 1'b1;
      out0_d           = glyph(code[src_lo]) | {7'b0, dp[src_lo]};
    end
    if (!dark_hi) begin
      seg_en_d[pos_hi] = 1'b1;
      out1_d           = glyph(code[src_hi]) | {7'b0, dp[src_hi]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      scroll_cnt_q <= '0;
      offset_q     <= '0;
      seg_en_q     <= '0;
      out0_q       <= 8'h00;
      out1_q       <= 8'h00;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      scroll_cnt_q <= scroll_cnt_d;
      offset_q     <= offset_d;
      seg_en_q     <= seg_en_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
    end
  end

  assign seg_en   = seg_en_q;
  assign seg_out0 = out0_q;
  assign seg_out1 = out1_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: an 8-digit and a 6-digit instance
// with short dividers so scan, blink and scroll periods fit in a few hundred cycles.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] digits8 = 32'h012A456E;
  logic [7:0]  dp8 = '0, blank8 = '0, blink8 = '0;
  logic        scroll8 = 1'b0;
  logic [7:0]  en8, o0_8, o1_8;

  logic [23:0] digits6 = 24'h012345;
  logic [5:0]  dp6 = '0, blank6 = '0, blink6 = '0;
  logic        scroll6 = 1'b0;
  logic [5:0]  en6;
  logic [7:0]  o0_6, o1_6;

  int vecs = 0;
  int errs = 0;

  // Codes of digits 0..7 for 32'h012A456E, leftmost first.
  logic [3:0] dig8 [8] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'hE};

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(64), .SCROLL_DIV(32)) u8 (
    .clk(clk), .rst(rst), .digits(digits8), .dp(dp8), .blank(blank8), .blink(blink8),
    .scroll_en(scroll8), .seg_en(en8), .seg_out0(o0_8), .seg_out1(o1_8)
  );

  seg_scan_display #(.DIGITS(6), .SCAN_DIV(4), .BLINK_DIV(64), .SCROLL_DIV(32)) u6 (
    .clk(clk), .rst(rst), .digits(digits6), .dp(dp6), .blank(blank6), .blink(blink6),
    .scroll_en(scroll6), .seg_en(en6), .seg_out0(o0_6), .seg_out1(o1_6)
  );

  function automatic logic [7:0] hexseg(input logic [3:0] c);
    logic [7:0] t [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    return t[c];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rst low #1 after an edge; the next edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vecs++; if (en8 !== 8'h00) begin errs++; $display("FAIL reset_en got %h exp 00", en8); end
    vecs++; if (o0_8 !== 8'h00) begin errs++; $display("FAIL reset_o0 got %h exp 00", o0_8); end
    vecs++; if (o1_8 !== 8'h00) begin errs++; $display("FAIL reset_o1 got %h exp 00", o1_8); end
    step(1);
    rst = 1'b0;
    step(1);
    vecs++; if (en8 !== 8'h11) begin errs++; $display("FAIL scan0_en got %h exp 11", en8); end
    vecs++; if (o0_8 !== 8'hFC) begin errs++; $display("FAIL scan0_o0 got %h exp FC", o0_8); end
    vecs++; if (o1_8 !== 8'h66) begin errs++; $display("FAIL scan0_o1 got %h exp 66", o1_8); end
    step(4);
    vecs++; if (en8 !== 8'h22) begin errs++; $display("FAIL scan1_en got %h exp 22", en8); end
    vecs++; if (o0_8 !== 8'h60) begin errs++; $display("FAIL scan1_o0 got %h exp 60", o0_8); end
    vecs++; if (o1_8 !== 8'hB6) begin errs++; $display("FAIL scan1_o1 got %h exp B6", o1_8); end
    step(4);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h44, 8'hDA, 8'hBE}) begin
      errs++; $display("FAIL scan2 got %h %h %h exp 44 DA BE", en8, o0_8, o1_8); end
    step(4);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h88, 8'hEE, 8'h9E}) begin
      errs++; $display("FAIL scan3 got %h %h %h exp 88 EE 9E", en8, o0_8, o1_8); end
    step(4);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h11, 8'hFC, 8'h66}) begin
      errs++; $display("FAIL scan_wrap got %h %h %h exp 11 FC 66", en8, o0_8, o1_8); end
  endtask

  task automatic test_dp_blank();
    dp8 = 8'h01; blank8 = 8'h10;
    do_reset();
    step(1);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h01, 8'hFD, 8'h00}) begin
      errs++; $display("FAIL dp_blank got %h %h %h exp 01 FD 00", en8, o0_8, o1_8); end
    step(4);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h22, 8'h60, 8'hB6}) begin
      errs++; $display("FAIL dp_blank_idx1 got %h %h %h exp 22 60 B6", en8, o0_8, o1_8); end
    dp8 = '0; blank8 = '0;
  endtask

  task automatic test_blink();
    blink8 = 8'h01;
    do_reset();
    step(1);    // edge 1: phase on, index 0
    vecs++; if ({en8, o0_8, o1_8} !== {8'h11, 8'hFC, 8'h66}) begin
      errs++; $display("FAIL blink_on1 got %h %h %h exp 11 FC 66", en8, o0_8, o1_8); end
    step(48);   // edge 49: still on, index 0
    vecs++; if ({en8, o0_8, o1_8} !== {8'h11, 8'hFC, 8'h66}) begin
      errs++; $display("FAIL blink_on49 got %h %h %h exp 11 FC 66", en8, o0_8, o1_8); end
    step(16);   // edge 65: off-phase, index 0
    vecs++; if ({en8, o0_8, o1_8} !== {8'h10, 8'h00, 8'h66}) begin
      errs++; $display("FAIL blink_off65 got %h %h %h exp 10 00 66", en8, o0_8, o1_8); end
    step(48);   // edge 113: still off
    vecs++; if ({en8, o0_8, o1_8} !== {8'h10, 8'h00, 8'h66}) begin
      errs++; $display("FAIL blink_off113 got %h %h %h exp 10 00 66", en8, o0_8, o1_8); end
    step(16);   // edge 129: back on
    vecs++; if ({en8, o0_8, o1_8} !== {8'h11, 8'hFC, 8'h66}) begin
      errs++; $display("FAIL blink_on129 got %h %h %h exp 11 FC 66", en8, o0_8, o1_8); end
    blink8 = '0;
  endtask

  task automatic test_scroll_wrap();
    logic [7:0] e0, e1;
    scroll8 = 1'b1;
    do_reset();
    step(1);
    // Edge 32k+1 shows offset k mod 8 at index 0.
    for (int k = 0; k <= 8; k++) begin
      e0 = hexseg(dig8[k % 8]);
      e1 = hexseg(dig8[(k + 4) % 8]);
      vecs++; if ({en8, o0_8, o1_8} !== {8'h11, e0, e1}) begin
        errs++; $display("FAIL scroll_off%0d got %h %h %h exp 11 %h %h", k, en8, o0_8, o1_8,
                         e0, e1); end
      if (k < 8) step(32);
    end
    scroll8 = 1'b0;
  endtask

  task automatic test_scroll_drop();
    dp8 = 8'h08;  // dp on digit 3: must follow the rotation
    scroll8 = 1'b1;
    do_reset();
    step(1);
    vecs++; if (o0_8 !== 8'hFC) begin errs++; $display("FAIL rot_dp_off0 got %h exp FC", o0_8); end
    step(96);   // edge 97: offset 3, index 0
    vecs++; if (o0_8 !== 8'hEF) begin errs++; $display("FAIL rot_dp_off3 got %h exp EF", o0_8); end
    scroll8 = 1'b0;
    step(1);    // edge 98: offset cleared on this edge, output still rotated
    vecs++; if (o0_8 !== 8'hEF) begin errs++; $display("FAIL drop_hold got %h exp EF", o0_8); end
    step(1);    // edge 99: unrotated, index 0
    vecs++; if ({en8, o0_8, o1_8} !== {8'h11, 8'hFC, 8'h66}) begin
      errs++; $display("FAIL drop_unrot got %h %h %h exp 11 FC 66", en8, o0_8, o1_8); end
    dp8 = '0;
  endtask

  task automatic test_six_digits();
    scroll6 = 1'b0;
    do_reset();
    step(1);
    vecs++; if ({en6, o0_6, o1_6} !== {6'h09, 8'hFC, 8'hF2}) begin
      errs++; $display("FAIL six_idx0 got %h %h %h exp 09 FC F2", en6, o0_6, o1_6); end
    step(4);
    vecs++; if ({en6, o0_6, o1_6} !== {6'h12, 8'h60, 8'h66}) begin
      errs++; $display("FAIL six_idx1 got %h %h %h exp 12 60 66", en6, o0_6, o1_6); end
    step(4);
    vecs++; if ({en6, o0_6, o1_6} !== {6'h24, 8'hDA, 8'hB6}) begin
      errs++; $display("FAIL six_idx2 got %h %h %h exp 24 DA B6", en6, o0_6, o1_6); end
    step(4);
    vecs++; if ({en6, o0_6, o1_6} !== {6'h09, 8'hFC, 8'hF2}) begin
      errs++; $display("FAIL six_idx_wrap got %h %h %h exp 09 FC F2", en6, o0_6, o1_6); end

    scroll6 = 1'b1;
    do_reset();
    for (int n = 1; n <= 193; n++) begin
      step(1);
      vecs++; if ($countones(en6) != 2) begin
        errs++; $display("FAIL six_two_lit edge %0d got %b exp two bits", n, en6); end
      if (n == 161) begin  // offset 5, index 1: sources 0 and 3
        vecs++; if ({en6, o0_6, o1_6} !== {6'h12, 8'hFC, 8'hF2}) begin
          errs++; $display("FAIL six_off5 got %h %h %h exp 12 FC F2", en6, o0_6, o1_6); end
      end
      if (n == 193) begin  // offset wrapped to 0, index 0
        vecs++; if ({en6, o0_6, o1_6} !== {6'h09, 8'hFC, 8'hF2}) begin
          errs++; $display("FAIL six_off_wrap got %h %h %h exp 09 FC F2", en6, o0_6, o1_6); end
      end
    end
    scroll6 = 1'b0;
  endtask

  task automatic test_mid_reset();
    scroll8 = 1'b1;
    do_reset();
    step(105);  // edge 105: offset 3, index 2 -> sources 5 and 1
    vecs++; if ({en8, o0_8, o1_8} !== {8'h44, 8'hB6, 8'h60}) begin
      errs++; $display("FAIL mid_pre got %h %h %h exp 44 B6 60", en8, o0_8, o1_8); end
    #2;
    rst = 1'b1;
    #1;
    vecs++; if ({en8, o0_8, o1_8} !== 24'h0) begin
      errs++; $display("FAIL mid_rst got %h %h %h exp 00 00 00", en8, o0_8, o1_8); end
    scroll8 = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h11, 8'hFC, 8'h66}) begin
      errs++; $display("FAIL mid_after0 got %h %h %h exp 11 FC 66", en8, o0_8, o1_8); end
    step(4);
    vecs++; if ({en8, o0_8, o1_8} !== {8'h22, 8'h60, 8'hB6}) begin
      errs++; $display("FAIL mid_after1 got %h %h %h exp 22 60 B6", en8, o0_8, o1_8); end
  endtask

  initial begin
    test_reset();
    test_dp_blank();
    test_blink();
    test_scroll_wrap();
    test_scroll_drop();
    test_six_digits();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
